// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet frame writer.
// Imported by the writer top and its read-data FIFO.
package eth_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int MAC_W      = 48;
    localparam int ETYPE_W    = 16;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/eth_skid_fifo.sv
// Two-entry show-ahead FIFO with synchronous flush.
// Head word is visible on rd_data whenever the FIFO is not empty.
module eth_skid_fifo
    import eth_frame_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         empty
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wp;
    logic         rp;

    assign rd_data = mem[rp];
    assign empty   = (count == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= ~wp;
            end
            if (rd_en) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/eth_frame_writer.sv
// Ethernet frame writer: latches a header, hands it to the TX framer,
// then streams payload beats fetched from a synchronous-read memory.
module eth_frame_writer
    import eth_frame_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 16,
    parameter int          LEN_WIDTH  = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MAC_W-1:0]      dest_mac,
    input  logic [MAC_W-1:0]      src_mac,
    input  logic [ETYPE_W-1:0]    eth_type,
    input  logic [LEN_WIDTH-1:0]  payload_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pl_raddr,
    output logic                  pl_ren,
    input  logic [DATA_WIDTH-1:0] pl_rdata,
    output logic                  s_eth_hdr_valid,
    input  logic                  s_eth_hdr_ready,
    output logic [MAC_W-1:0]      s_eth_dest_mac,
    output logic [MAC_W-1:0]      s_eth_src_mac,
    output logic [ETYPE_W-1:0]    s_eth_type,
    output logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    output logic                  s_eth_payload_axis_tvalid,
    input  logic                  s_eth_payload_axis_tready,
    output logic                  s_eth_payload_axis_tlast,
    output logic                  s_eth_payload_axis_tuser
);

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] rd_idx;
    logic [LEN_WIDTH-1:0] sent;
    logic                 abort_q;
    logic                 rvalid_q;
    logic [1:0]           fifo_count;
    logic                 fifo_empty;
    logic                 in_pl;
    logic                 aborting;
    logic                 pop;
    logic                 last_beat;
    logic                 can_read;
    logic [2:0]           occ;

    assign in_pl     = (state == PAYLOAD);
    assign aborting  = abort_q | abort;
    assign last_beat = (sent == len_q - 1'b1);
    assign pop       = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;

    assign s_eth_payload_axis_tvalid = in_pl & ~fifo_empty;
    assign s_eth_payload_axis_tlast  = s_eth_payload_axis_tvalid & (last_beat | aborting);
    assign s_eth_payload_axis_tuser  = s_eth_payload_axis_tvalid & aborting;

    // Occupancy after this cycle's pop; counting the pop keeps 1 beat/cycle.
    assign occ = {1'b0, fifo_count} + {2'b0, rvalid_q} - {2'b0, pop};

    // While aborting, fetch only if nothing is left to become the error beat.
    assign can_read = aborting ? (fifo_empty & ~rvalid_q)
                               : (occ < 3'(FIFO_DEPTH));
    assign pl_ren   = in_pl & (rd_idx != len_q) & can_read;
    assign pl_raddr = pl_ren ? ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_idx)
                             : '0;

    eth_skid_fifo #(
        .W(DATA_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (pop & s_eth_payload_axis_tlast),
        .wr_en  (in_pl & rvalid_q),
        .wr_data(pl_rdata),
        .rd_en  (pop),
        .rd_data(s_eth_payload_axis_tdata),
        .count  (fifo_count),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            s_eth_hdr_valid <= 1'b0;
            s_eth_dest_mac  <= '0;
            s_eth_src_mac   <= '0;
            s_eth_type      <= '0;
            len_q           <= '0;
            rd_idx          <= '0;
            sent            <= '0;
            abort_q         <= 1'b0;
            rvalid_q        <= 1'b0;
        end else begin
            done     <= 1'b0;
            rvalid_q <= pl_ren;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_eth_dest_mac  <= dest_mac;
                        s_eth_src_mac   <= src_mac;
                        s_eth_type      <= eth_type;
                        len_q           <= payload_len;
                        rd_idx          <= '0;
                        sent            <= '0;
                        abort_q         <= 1'b0;
                        busy            <= 1'b1;
                        s_eth_hdr_valid <= 1'b1;
                        state           <= HDR;
                    end
                end
                HDR: begin
                    if (s_eth_hdr_ready) begin
                        s_eth_hdr_valid <= 1'b0;
                        if (len_q == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (pl_ren) begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (pop) begin
                        sent <= sent + 1'b1;
                        if (s_eth_payload_axis_tlast) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_writer.sv
// Self-checking bench for eth_frame_writer with a synchronous payload
// memory model and a beat scoreboard.
module tb_eth_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [15:0] payload_len;
    logic        busy;
    logic        done;
    logic [15:0] pl_raddr;
    logic        pl_ren;
    logic [7:0]  pl_rdata;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] o_dest;
    logic [47:0] o_src;
    logic [15:0] o_type;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t sb[$];
    beat_t obs[$];
    int    checks = 0;
    int    errors = 0;
    int    ren_cnt = 0;
    logic [7:0] salt = 8'h00;

    eth_frame_writer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .LEN_WIDTH (16),
        .BASE_ADDR (0)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .abort                    (abort),
        .dest_mac                 (dest_mac),
        .src_mac                  (src_mac),
        .eth_type                 (eth_type),
        .payload_len              (payload_len),
        .busy                     (busy),
        .done                     (done),
        .pl_raddr                 (pl_raddr),
        .pl_ren                   (pl_ren),
        .pl_rdata                 (pl_rdata),
        .s_eth_hdr_valid          (hdr_valid),
        .s_eth_hdr_ready          (hdr_ready),
        .s_eth_dest_mac           (o_dest),
        .s_eth_src_mac            (o_src),
        .s_eth_type               (o_type),
        .s_eth_payload_axis_tdata (tdata),
        .s_eth_payload_axis_tvalid(tvalid),
        .s_eth_payload_axis_tready(tready),
        .s_eth_payload_axis_tlast (tlast),
        .s_eth_payload_axis_tuser (tuser)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a holds a[7:0] + salt.
    always @(posedge clk) begin
        if (pl_ren) begin
            pl_rdata <= pl_raddr[7:0] + salt;
            ren_cnt  <= ren_cnt + 1;
        end else begin
            pl_rdata <= 8'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk(input int i, input int n, input int ab);
        beat_t b;
        b.data = 8'(i) + salt;
        b.last = (i == n - 1) || (i == ab);
        b.user = (i == ab);
        return b;
    endfunction

    task automatic push_beats(input int n, input int ab);
        for (int i = 0; i < n; i++) begin
            if (ab >= 0 && i > ab) break;
            sb.push_back(mk(i, n, ab));
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the next cycle.
    task automatic start_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input logic [15:0] n);
        dest_mac    = d;
        src_mac     = s;
        eth_type    = t;
        payload_len = n;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        dest_mac    = {16'hBAD0, 32'($urandom)};
        src_mac     = {16'hBAD1, 32'($urandom)};
        eth_type    = 16'($urandom);
        payload_len = 16'($urandom);
    endtask

    // Drives tready/abort and records transferred beats; cycle 0 is the
    // cycle in which it is called.
    task automatic capture(input int max_cyc, input logic [3:0] pat,
                           input int abort_at, output int first,
                           output int lastc, output int donec,
                           output int holdbad, output int ovf);
        int         r0;
        logic       held;
        logic [7:0] hd;
        logic       hl;
        logic       fired;
        first   = -1;
        lastc   = -1;
        donec   = -1;
        holdbad = 0;
        ovf     = 0;
        held    = 1'b0;
        hd      = '0;
        hl      = 1'b0;
        fired   = 1'b0;
        r0      = ren_cnt;
        obs.delete();
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            tready = pat[2'(cyc)];
            abort  = (abort_at >= 0) && (obs.size() == abort_at) && !fired;
            if (abort) fired = 1'b1;
            @(negedge clk);
            if (held && (!tvalid || tdata !== hd || tlast !== hl)) holdbad++;
            held = tvalid && !tready;
            hd   = tdata;
            hl   = tlast;
            if ((ren_cnt - r0) + int'(pl_ren) - obs.size()
                - int'(tvalid && tready) > 2) ovf++;
            if (tvalid && tready) begin
                obs.push_back({tdata, tlast, tuser});
                if (first < 0) first = cyc;
                lastc = cyc;
            end
            if (done) begin
                donec = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        tready = 1'b1;
        abort  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pl_ren, hdr_valid, tvalid, tlast, tuser} !== 7'b0) begin
            errors++;
            $display("FAIL rst_ctrl: got %b want 0000000",
                     {busy, done, pl_ren, hdr_valid, tvalid, tlast, tuser});
        end
        checks++;
        if (pl_raddr !== 16'h0) begin
            errors++;
            $display("FAIL rst_addr: got %h want 0000", pl_raddr);
        end
        checks++;
        if ({o_dest, o_src, o_type} !== 112'h0) begin
            errors++;
            $display("FAIL rst_hdr: got %h %h %h want zeros", o_dest, o_src, o_type);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_header_only();
        int r0;
        hdr_ready = 1'b1;
        r0 = ren_cnt;
        start_frame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 16'd0);
        @(negedge clk);
        checks++;
        if (!hdr_valid || o_dest !== 48'h0A0B0C0D0E0F || o_src !== 48'h112233445566
            || o_type !== 16'h0800) begin
            errors++;
            $display("FAIL hdr_fields: got v=%b %h %h %h want 1 0a0b0c0d0e0f 112233445566 0800",
                     hdr_valid, o_dest, o_src, o_type);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({hdr_valid, done, busy, tvalid} !== 4'b0110) begin
            errors++;
            $display("FAIL hdr_done: got v/done/busy/tvalid=%b want 0110",
                     {hdr_valid, done, busy, tvalid});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({done, busy, ren_cnt - r0} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL hdr_idle: got done=%b busy=%b reads=%0d want 0 0 0",
                     done, busy, ren_cnt - r0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_throughput();
        int    first, lastc, donec, holdbad, ovf, r0;
        beat_t got, exp;
        salt = 8'h10;
        push_beats(4, -1);
        r0 = ren_cnt;
        start_frame(48'h020000000001, 48'h020000000002, 16'h0800, 16'd4);
        capture(40, 4'b1111, -1, first, lastc, donec, holdbad, ovf);
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL tp_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0) begin
            errors++;
            $display("FAIL tp_count: %0d extra observed, %0d missing",
                     obs.size(), sb.size());
        end
        checks++;
        if (first != 3 || lastc != 6 || donec != 7) begin
            errors++;
            $display("FAIL tp_timing: got first=%0d last=%0d done=%0d want 3 6 7",
                     first, lastc, donec);
        end
        checks++;
        if (ren_cnt - r0 != 4) begin
            errors++;
            $display("FAIL tp_reads: got %0d reads want 4", ren_cnt - r0);
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_backpressure();
        int    first, lastc, donec, holdbad, ovf, r0;
        beat_t got, exp;
        salt = 8'h40;
        push_beats(6, -1);
        r0 = ren_cnt;
        start_frame(48'h0200000000A1, 48'h0200000000A2, 16'h88B5, 16'd6);
        capture(80, 4'b1001, -1, first, lastc, donec, holdbad, ovf);
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bp_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0 || donec < 0) begin
            errors++;
            $display("FAIL bp_count: %0d extra, %0d missing, done_cycle=%0d",
                     obs.size(), sb.size(), donec);
        end
        checks++;
        if (holdbad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stalled cycles want 0", holdbad);
        end
        checks++;
        if (ovf != 0 || ren_cnt - r0 != 6) begin
            errors++;
            $display("FAIL bp_outstanding: got %0d overflows, %0d reads want 0, 6",
                     ovf, ren_cnt - r0);
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_header_stall();
        int    first, lastc, donec, holdbad, ovf;
        int    bad;
        beat_t got, exp;
        salt = 8'h70;
        push_beats(3, -1);
        hdr_ready = 1'b0;
        bad = 0;
        start_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 16'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!hdr_valid || o_dest !== 48'hA1A2A3A4A5A6 || o_src !== 48'hB1B2B3B4B5B6
                || o_type !== 16'h86DD || tvalid || pl_ren) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d bad stalled cycles want 0", bad);
        end
        hdr_ready = 1'b1;
        capture(40, 4'b1111, -1, first, lastc, donec, holdbad, ovf);
        checks++;
        if (first != 3 || donec != 6) begin
            errors++;
            $display("FAIL stall_timing: got first=%0d done=%0d want 3 6", first, donec);
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0) begin
            errors++;
            $display("FAIL stall_count: %0d extra, %0d missing", obs.size(), sb.size());
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_abort();
        int    first, lastc, donec, holdbad, ovf;
        beat_t got, exp;
        salt = 8'h20;
        push_beats(8, 3);
        start_frame(48'h0200000000C1, 48'h0200000000C2, 16'h0800, 16'd8);
        capture(40, 4'b1111, 3, first, lastc, donec, holdbad, ovf);
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0 || donec != lastc + 1) begin
            errors++;
            $display("FAIL abort_end: %0d extra, %0d missing, last=%0d done=%0d",
                     obs.size(), sb.size(), lastc, donec);
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_back_to_back();
        int    first, lastc, donec, holdbad, ovf;
        beat_t got, exp;
        salt = 8'h30;
        push_beats(2, -1);
        start_frame(48'h0200000000D1, 48'h0200000000D2, 16'h0806, 16'd2);
        capture(40, 4'b1111, -1, first, lastc, donec, holdbad, ovf);
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0 || donec != 5) begin
            errors++;
            $display("FAIL b2b_count: %0d extra, %0d missing, done=%0d want done 5",
                     obs.size(), sb.size(), donec);
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_reset_mid();
        int    first, lastc, donec, holdbad, ovf;
        int    bad;
        beat_t got, exp;
        salt = 8'h50;
        start_frame(48'h0200000000E1, 48'h0200000000E2, 16'h0800, 16'd6);
        capture(5, 4'b1111, -1, first, lastc, donec, holdbad, ovf);
        checks++;
        if (obs.size() != 2 || donec != -1) begin
            errors++;
            $display("FAIL rmid_pre: got %0d beats done=%0d want 2 beats, no done",
                     obs.size(), donec);
        end
        obs.delete();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, pl_ren, hdr_valid, tvalid, tlast, tuser} !== 7'b0
            || pl_raddr !== 16'h0 || {o_dest, o_src, o_type} !== 112'h0) begin
            errors++;
            $display("FAIL rmid_async: got ctrl=%b addr=%h hdr=%h want all zero",
                     {busy, done, pl_ren, hdr_valid, tvalid, tlast, tuser},
                     pl_raddr, {o_dest, o_src, o_type});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rmid_nodone: got %0d cycles with done/busy want 0", bad);
        end
        salt = 8'h60;
        push_beats(3, -1);
        start_frame(48'h0200000000F1, 48'h0200000000F2, 16'h0800, 16'd3);
        capture(40, 4'b1111, -1, first, lastc, donec, holdbad, ovf);
        while (sb.size() > 0 && obs.size() > 0) begin
            exp = sb.pop_front();
            got = obs.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rmid_beat: got %h/%b/%b want %h/%b/%b",
                         got.data, got.last, got.user, exp.data, exp.last, exp.user);
            end
        end
        checks++;
        if (sb.size() != 0 || obs.size() != 0 || donec < 0) begin
            errors++;
            $display("FAIL rmid_count: %0d extra, %0d missing, done=%0d",
                     obs.size(), sb.size(), donec);
        end
        sb.delete();
        obs.delete();
    endtask

    task automatic test_start_held();
        logic [1:0] exp_vd;
        logic [1:0] got_vd;
        hdr_ready   = 1'b1;
        dest_mac    = 48'h0200000000AA;
        src_mac     = 48'h0200000000BB;
        eth_type    = 16'h0800;
        payload_len = 16'd0;
        start       = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            exp_vd = {(k % 3 == 0), (k % 3 == 1)};
            got_vd = {hdr_valid, done};
            checks++;
            if (got_vd !== exp_vd) begin
                errors++;
                $display("FAIL held_start k=%0d: got hdr_valid/done=%b want %b",
                         k, got_vd, exp_vd);
            end
            if (k == 8) start = 1'b0;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({hdr_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL held_stop: got hdr_valid/busy=%b want 00", {hdr_valid, busy});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        dest_mac    = '0;
        src_mac     = '0;
        eth_type    = '0;
        payload_len = '0;
        hdr_ready   = 1'b1;
        tready      = 1'b1;
        test_reset();
        test_header_only();
        test_throughput();
        test_backpressure();
        test_header_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_writer.md
Name: eth_frame_writer

Overview:
- Parametrised successor to the single-shot Ethernet header writer.
- Per start pulse: latches dest MAC, src MAC and EtherType, sends the header on the eth_axis_tx-style header handshake, then streams payload_len payload beats read from a synchronous-read payload memory.
- Payload goes out on the AXI-Stream payload port, with tlast on the final beat and tuser on abort.
- Re-triggerable. Sits between HLS-generated packet-building logic and the Ethernet TX framer.

Parameters:
- DATA_WIDTH, 8: payload beat width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 16: payload memory address width.
- LEN_WIDTH, 16: width of payload_len, in beats.
- BASE_ADDR, 0: payload memory address of beat 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  terminate payload early with error.
- dest_mac  in  48  frame destination MAC; latched on start.
- src_mac  in  48  frame source MAC; latched on start.
- eth_type  in  16  EtherType; latched on start.
- payload_len  in  LEN_WIDTH  beat count; latched on start; 0 is legal.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse at frame completion.
- pl_raddr  out  ADDR_WIDTH  payload memory read address.
- pl_ren  out  1  read enable.
- pl_rdata  in  DATA_WIDTH  read data; valid exactly 1 cycle after pl_ren.
- s_eth_hdr_valid  out  1  header handshake valid.
- s_eth_hdr_ready  in  1  header handshake ready.
- s_eth_dest_mac  out  48  latched dest MAC.
- s_eth_src_mac  out  48  latched src MAC.
- s_eth_type  out  16  latched EtherType.
- s_eth_payload_axis_tdata  out  DATA_WIDTH  payload beat.
- s_eth_payload_axis_tvalid  out  1  payload beat valid.
- s_eth_payload_axis_tready  in  1  payload beat ready.
- s_eth_payload_axis_tlast  out  1  final beat of frame.
- s_eth_payload_axis_tuser  out  1  frame error; only with tlast.

Behaviour:
- Reset (rst low, asynchronous):
  - State forced to IDLE; read FIFO cleared.
  - Outputs forced low: busy, done, pl_ren, hdr_valid, tvalid, tlast, tuser, pl_raddr.
  - Header field registers forced to 0.
  - Reset mid-frame discards the frame; no done pulse.
- States: IDLE, HDR, PAYLOAD, DONE.
- IDLE:
  - start=1 latches dest_mac, src_mac, eth_type and payload_len into registers, and sets beat counter = 0.
  - Next state HDR.
  - abort is ignored in IDLE.
- HDR:
  - s_eth_hdr_valid=1 from the cycle after start.
  - Header outputs are held stable until s_eth_hdr_valid and s_eth_hdr_ready are both high.
  - On that handshake: to PAYLOAD if len>0, else to DONE.
  - abort in HDR is ignored; the header must complete.
- PAYLOAD, read side:
  - Reads are issued at addresses BASE_ADDR+0 … BASE_ADDR+len-1.
  - Read data enters a 2-entry show-ahead FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2, so data is never dropped under backpressure.
- PAYLOAD, output side:
  - tvalid equals FIFO non-empty.
  - A beat transfers when tvalid && tready; it pops the FIFO and increments the sent count.
  - tlast=1 on the beat where sent count == len-1.
  - Sustained throughput is 1 beat/cycle with tready held high, after a first-beat latency of 2 cycles from entering PAYLOAD.
  - tdata, tvalid and tlast are held stable while tready is low.
- Abort:
  - Asserted in PAYLOAD: no further reads are issued.
  - The next transferred beat (FIFO head) carries tlast=1 and tuser=1; all other FIFO and in-flight data is discarded.
  - If abort coincides with the natural last beat, that beat carries tlast=1 and tuser=1.
- Transition to DONE: on the tlast handshake.
- DONE:
  - done=1 for exactly 1 cycle, then IDLE.
  - start arriving in the DONE cycle is ignored; the next frame may start the following cycle.
- Width rules:
  - Address = BASE_ADDR + beat index, truncated to ADDR_WIDTH and wrapping modulo 2^ADDR_WIDTH.
  - payload_len = 2^LEN_WIDTH-1 is supported; counters are LEN_WIDTH bits wide.
- tuser is 0 on every non-abort beat.

Decomposition:
- Shared package eth_frame_pkg holds:
  - the state enum (IDLE=0, HDR=1, PAYLOAD=2, DONE=3);
  - widths MAC_W=48 and ETYPE_W=16;
  - FIFO_DEPTH=2.
- One sub-module: eth_skid_fifo, a parametrised 2-entry show-ahead FIFO with flush input, used for the read-data buffer.

Test Plan:
1. Header only: dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, len=0, hdr_ready=1 → hdr_valid high 1 cycle with those values; no tvalid; done pulses 1 cycle after the handshake; busy drops with it.
2. Full throughput: DATA_WIDTH=8, mem[i]=i+0x10, len=4, tready=1 → beats 0x10, 0x11, 0x12, 0x13 on consecutive cycles; tlast only on 0x13; tuser=0; exactly 4 pl_ren pulses.
3. Backpressure: len=6, tready toggled 1,0,0,1,… → sequence intact with no duplicates or drops; tdata stable while tready is low; FIFO never exceeds 2 entries.
4. Header stall: hdr_ready low for 5 cycles → header fields stable and hdr_valid held high; payload starts only after the handshake.
5. Abort: len=8, abort pulsed after beat 2 → beat 3 carries tlast=1 and tuser=1; no beats 4–7; done pulses; the next start with len=2 then works normally.
6. Async reset mid-PAYLOAD (rst low between clock edges) → all outputs 0 immediately; no done pulse; a subsequent frame is correct. Also: start held high through DONE triggers the next frame exactly once per IDLE visit.
